// File: rtl/ir_nec_decoder.sv
// NEC-style IR frame decoder: synchronizes the receiver line, times marks/spaces
// in prescaled ticks and emits the 32-bit code or a repeat/error pulse.
module ir_nec_decoder #(
  parameter int TICK_CYCLES = 742
) (
  input  logic        clk_pixel_in,
  input  logic        rst_n_in,
  input  logic        ir_in,
  output logic [31:0] decoded_ir_out,
  output logic        decoded_ir_valid_out,
  output logic        repeat_out,
  output logic        error_out
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  localparam logic [9:0] LEAD_MARK_MIN  = 10'd800;
  localparam logic [9:0] LEAD_MARK_MAX  = 10'd1000;
  localparam logic [9:0] LEAD_SPACE_MIN = 10'd400;
  localparam logic [9:0] LEAD_SPACE_MAX = 10'd500;
  localparam logic [9:0] RPT_SPACE_MIN  = 10'd200;
  localparam logic [9:0] RPT_SPACE_MAX  = 10'd250;
  localparam logic [9:0] MARK_MIN       = 10'd40;
  localparam logic [9:0] MARK_MAX       = 10'd70;
  localparam logic [9:0] ZERO_MIN       = 10'd40;
  localparam logic [9:0] ZERO_MAX       = 10'd90;
  localparam logic [9:0] ONE_MIN        = 10'd130;
  localparam logic [9:0] ONE_MAX        = 10'd210;
  localparam logic [9:0] WIDTH_SAT      = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  logic [PRE_W-1:0]  r_pre;
  logic [9:0]        r_width;
  logic [31:0]       r_shift;
  logic [4:0]        r_bit_cnt;
  logic              r_rpt;

  logic              w_fall;
  logic              w_rise;
  logic              w_edge;
  logic              w_exp_edge;
  logic              w_win_ok;
  logic [9:0]        w_win_max;
  logic              w_timeout;
  logic              w_abort;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == WIDTH_SAT) ? v : v + 10'd1;
  endfunction

  function automatic logic in_win(input logic [9:0] v, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Synchronizer and edge-detect flops idle high so reset never fakes an edge
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= ir_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;
  assign w_rise = ~r_prev & r_sync2;
  assign w_edge = w_fall | w_rise;

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pre   <= '0;
      r_width <= '0;
    end else if (w_edge) begin
      r_pre   <= '0;
      r_width <= '0;
    end else if (r_pre == PRE_LAST) begin
      r_pre   <= '0;
      r_width <= sat_inc(r_width);
    end else begin
      r_pre   <= r_pre + PRE_W'(1);
    end
  end

  // Per-state expected edge, acceptance window and timeout ceiling
  always_comb begin
    w_exp_edge = 1'b0;
    w_win_ok   = 1'b0;
    w_win_max  = WIDTH_SAT;
    case (r_state)
      S_LEAD_MARK: begin
        w_exp_edge = w_rise;
        w_win_ok   = in_win(r_width, LEAD_MARK_MIN, LEAD_MARK_MAX);
        w_win_max  = LEAD_MARK_MAX;
      end
      S_LEAD_SPACE: begin
        w_exp_edge = w_fall;
        w_win_ok   = in_win(r_width, LEAD_SPACE_MIN, LEAD_SPACE_MAX) ||
                     in_win(r_width, RPT_SPACE_MIN, RPT_SPACE_MAX);
        w_win_max  = LEAD_SPACE_MAX;
      end
      S_BIT_MARK, S_STOP_MARK: begin
        w_exp_edge = w_rise;
        w_win_ok   = in_win(r_width, MARK_MIN, MARK_MAX);
        w_win_max  = MARK_MAX;
      end
      S_BIT_SPACE: begin
        w_exp_edge = w_fall;
        w_win_ok   = in_win(r_width, ZERO_MIN, ZERO_MAX) ||
                     in_win(r_width, ONE_MIN, ONE_MAX);
        w_win_max  = ONE_MAX;
      end
      default: begin
        w_exp_edge = w_fall;
        w_win_ok   = 1'b1;
        w_win_max  = WIDTH_SAT;
      end
    endcase
  end

  // An edge always takes priority over the timeout; its width is judged instead
  assign w_timeout = (r_state != S_IDLE) && (r_width > w_win_max);
  assign w_abort   = (r_state != S_IDLE) && (w_exp_edge ? !w_win_ok : w_timeout);

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state              <= S_IDLE;
      r_shift              <= '0;
      r_bit_cnt            <= '0;
      r_rpt                <= 1'b0;
      decoded_ir_out       <= '0;
      decoded_ir_valid_out <= 1'b0;
      repeat_out           <= 1'b0;
      error_out            <= 1'b0;
    end else begin
      decoded_ir_valid_out <= 1'b0;
      repeat_out           <= 1'b0;
      error_out            <= 1'b0;
      if (w_abort) begin
        error_out <= 1'b1;
        r_state   <= S_IDLE;
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_rpt     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_fall) r_state <= S_LEAD_MARK;
          end
          S_LEAD_MARK: begin
            if (w_exp_edge) r_state <= S_LEAD_SPACE;
          end
          S_LEAD_SPACE: begin
            if (w_exp_edge) begin
              if (in_win(r_width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                r_state   <= S_BIT_MARK;
                r_bit_cnt <= '0;
                r_rpt     <= 1'b0;
              end else begin
                r_state   <= S_STOP_MARK;
                r_rpt     <= 1'b1;
              end
            end
          end
          S_BIT_MARK: begin
            if (w_exp_edge) r_state <= S_BIT_SPACE;
          end
          S_BIT_SPACE: begin
            if (w_exp_edge) begin
              r_shift <= {r_shift[30:0], in_win(r_width, ONE_MIN, ONE_MAX)};
              if (r_bit_cnt == 5'd31) begin
                r_state <= S_STOP_MARK;
                r_rpt   <= 1'b0;
              end else begin
                r_state   <= S_BIT_MARK;
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          S_STOP_MARK: begin
            if (w_exp_edge) begin
              if (r_rpt) begin
                repeat_out <= 1'b1;
              end else begin
                decoded_ir_out       <= r_shift;
                decoded_ir_valid_out <= 1'b1;
              end
              r_state   <= S_IDLE;
              r_shift   <= '0;
              r_bit_cnt <= '0;
              r_rpt     <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder: good frames, repeat, malformed frames,
// timeouts and mid-frame reset, with pulse counting and latency checks.
module tb_ir_nec_decoder;

  localparam int T = 2;

  logic        clk;
  logic        rst_n_in;
  logic        ir_in;
  logic [31:0] decoded_ir_out;
  logic        decoded_ir_valid_out;
  logic        repeat_out;
  logic        error_out;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_rep    = 0;
  int n_err    = 0;
  logic [31:0] prev_dec = '0;

  ir_nec_decoder #(.TICK_CYCLES(T)) dut (
    .clk_pixel_in         (clk),
    .rst_n_in             (rst_n_in),
    .ir_in                (ir_in),
    .decoded_ir_out       (decoded_ir_out),
    .decoded_ir_valid_out (decoded_ir_valid_out),
    .repeat_out           (repeat_out),
    .error_out            (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters plus exclusivity and code-update checks
  always @(negedge clk) begin
    if (decoded_ir_valid_out === 1'b1) n_valid++;
    if (repeat_out === 1'b1) n_rep++;
    if (error_out === 1'b1) n_err++;
    if (decoded_ir_valid_out | repeat_out | error_out) begin
      checks++;
      assert ($onehot({decoded_ir_valid_out, repeat_out, error_out})) else begin
        failures++;
        $error("FAIL pulse_onehot: observed=%b expected=one-hot",
               {decoded_ir_valid_out, repeat_out, error_out});
      end
    end
    if (rst_n_in && (decoded_ir_out !== prev_dec)) begin
      checks++;
      assert (decoded_ir_valid_out === 1'b1) else begin
        failures++;
        $error("FAIL code_change_without_valid: observed=%0h expected=%0h",
               decoded_ir_out, prev_dec);
      end
    end
    prev_dec = decoded_ir_out;
  end

  // Hold a level for N full ticks as seen by the width counter
  task automatic lvl(input logic v, input int ticks);
    ir_in = v;
    repeat (ticks * T + 1) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] code, input int nb, input int m,
                           input int s0, input int s1);
    for (int i = 31; i > 31 - nb; i--) begin
      lvl(1'b0, m);
      lvl(1'b1, code[i] ? s1 : s0);
    end
  endtask

  // Cycles from the current negedge until the selected pulse; -1 if none within bound
  task automatic wait_pulse(input int sel, input int bound, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < bound) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      case (sel)
        0:       hit = decoded_ir_valid_out;
        1:       hit = repeat_out;
        default: hit = error_out;
      endcase
    end
    if (!hit) n = -1;
  endtask

  task automatic send_frame(input logic [31:0] code, input int lm, input int ls,
                            input int m, input int s0, input int s1, input int st,
                            output int n);
    lvl(1'b0, lm);
    lvl(1'b1, ls);
    send_bits(code, 32, m, s0, s1);
    lvl(1'b0, st);
    ir_in = 1'b1;
    wait_pulse(0, 20, n);
  endtask

  initial begin
    int n, v0, r0, e0;
    rst_n_in = 1'b0;
    ir_in    = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_code", decoded_ir_out, 32'h0);
    chk("reset_valid", {31'b0, decoded_ir_valid_out}, 32'h0);
    chk("reset_repeat", {31'b0, repeat_out}, 32'h0);
    chk("reset_error", {31'b0, error_out}, 32'h0);
    rst_n_in = 1'b1;
    repeat (10) @(negedge clk);

    // Nominal frame
    v0 = n_valid; r0 = n_rep; e0 = n_err;
    send_frame(32'hDEADBEEF, 900, 450, 56, 56, 169, 56, n);
    repeat (10) @(negedge clk);
    chk("frame1_latency", n, 3);
    chk("frame1_valid_cnt", n_valid - v0, 1);
    chk("frame1_code", decoded_ir_out, 32'hDEADBEEF);
    chk("frame1_err_cnt", n_err - e0, 0);
    chk("frame1_rep_cnt", n_rep - r0, 0);

    // Repeat frame
    v0 = n_valid; r0 = n_rep; e0 = n_err;
    lvl(1'b0, 900);
    lvl(1'b1, 225);
    lvl(1'b0, 56);
    ir_in = 1'b1;
    wait_pulse(1, 20, n);
    repeat (10) @(negedge clk);
    chk("repeat_latency", n, 3);
    chk("repeat_cnt", n_rep - r0, 1);
    chk("repeat_valid_cnt", n_valid - v0, 0);
    chk("repeat_code_held", decoded_ir_out, 32'hDEADBEEF);
    chk("repeat_err_cnt", n_err - e0, 0);

    // Short leader mark
    v0 = n_valid; e0 = n_err;
    lvl(1'b0, 700);
    ir_in = 1'b1;
    wait_pulse(2, 20, n);
    repeat (20) @(negedge clk);
    chk("short_leader_err_latency", n, 3);
    chk("short_leader_err_cnt", n_err - e0, 1);
    chk("short_leader_valid_cnt", n_valid - v0, 0);

    // Frame at the window edges
    v0 = n_valid; e0 = n_err;
    send_frame(32'h20FACADE, 800, 500, 40, 90, 130, 70, n);
    repeat (10) @(negedge clk);
    chk("frame2_latency", n, 3);
    chk("frame2_valid_cnt", n_valid - v0, 1);
    chk("frame2_code", decoded_ir_out, 32'h20FACADE);
    chk("frame2_err_cnt", n_err - e0, 0);

    // Line left high after 20 bit marks: bit-space timeout
    v0 = n_valid; e0 = n_err;
    lvl(1'b0, 900);
    lvl(1'b1, 450);
    send_bits(32'hA5A5A5A5, 19, 56, 56, 169);
    lvl(1'b0, 56);
    ir_in = 1'b1;
    wait_pulse(2, 600, n);
    repeat (10) @(negedge clk);
    chk("space_timeout_latency", n, 211 * T + 4);
    chk("space_timeout_err_cnt", n_err - e0, 1);
    chk("space_timeout_valid_cnt", n_valid - v0, 0);
    chk("space_timeout_code_held", decoded_ir_out, 32'h20FACADE);

    // Bit space of 100 ticks falls between the bit windows
    v0 = n_valid; e0 = n_err;
    lvl(1'b0, 900);
    lvl(1'b1, 450);
    lvl(1'b0, 56);
    lvl(1'b1, 100);
    ir_in = 1'b0;
    wait_pulse(2, 20, n);
    chk("gap_space_err_latency", n, 3);
    repeat (40) @(negedge clk);
    ir_in = 1'b1;
    repeat (60) @(negedge clk);
    chk("gap_space_err_cnt", n_err - e0, 1);
    chk("gap_space_valid_cnt", n_valid - v0, 0);

    // Reset during bit 12, then a clean frame
    v0 = n_valid; e0 = n_err;
    lvl(1'b0, 900);
    lvl(1'b1, 450);
    send_bits(32'h12345678, 12, 56, 56, 169);
    ir_in = 1'b0;
    repeat (30) @(negedge clk);
    rst_n_in = 1'b0;
    #1;
    chk("midreset_code", decoded_ir_out, 32'h0);
    chk("midreset_valid", {31'b0, decoded_ir_valid_out}, 32'h0);
    chk("midreset_repeat", {31'b0, repeat_out}, 32'h0);
    chk("midreset_error", {31'b0, error_out}, 32'h0);
    ir_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("midreset_hold_code", decoded_ir_out, 32'h0);
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("midreset_err_cnt", n_err - e0, 0);
    send_frame(32'h20FACADE, 1000, 400, 70, 40, 210, 40, n);
    repeat (10) @(negedge clk);
    chk("frame3_latency", n, 3);
    chk("frame3_valid_cnt", n_valid - v0, 1);
    chk("frame3_code", decoded_ir_out, 32'h20FACADE);
    chk("frame3_err_cnt", n_err - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
